// File: rtl/mem_wb_pkg.sv
// Shared types for the posted-write buffer: downstream FSM states and the
// buffered entry layout.
package mem_wb_pkg;

  localparam int WORD_LSB = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    READ  = 2'd2
  } wb_state_e;

  typedef struct packed {
    logic [31:WORD_LSB] addr;
    logic [31:0]        data;
    logic               valid;
  } wb_entry_t;

endpackage

// File: rtl/mem_write_buffer_cam.sv
// FIFO storage for posted writes with a youngest-first address match used
// for read forwarding.
module wb_entry_cam
  import mem_wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   clrn,
  input  logic                   push_i,
  input  logic [31:WORD_LSB]     push_addr_i,
  input  logic [31:0]            push_data_i,
  input  logic                   pop_i,
  input  logic [31:WORD_LSB]     lookup_addr_i,
  output logic                   hit_o,
  output logic [31:0]            hit_data_o,
  output logic [31:WORD_LSB]     head_addr_o,
  output logic [31:0]            head_data_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   full_o,
  output logic                   empty_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  wb_entry_t         entries_q [DEPTH];
  logic [PW-1:0]     head_q, head_d;
  logic [PW-1:0]     tail_q, tail_d;
  logic [CW-1:0]     count_q, count_d;
  logic [PW-1:0]     idx;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (pop_i)  head_d = head_q + PW'(1);
    if (push_i) tail_d = tail_q + PW'(1);
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      for (int unsigned i = 0; i < DEPTH; i++) entries_q[i] <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (pop_i)  entries_q[head_q].valid <= 1'b0;
      if (push_i) entries_q[tail_q] <= '{addr: push_addr_i, data: push_data_i, valid: 1'b1};
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Walk backwards from the newest slot; the first valid match is the youngest.
  always_comb begin
    hit_o      = 1'b0;
    hit_data_o = '0;
    idx        = '0;
    for (int unsigned k = 1; k <= DEPTH; k++) begin
      idx = tail_q - PW'(k);
      if (!hit_o && entries_q[idx].valid && entries_q[idx].addr == lookup_addr_i) begin
        hit_o      = 1'b1;
        hit_data_o = entries_q[idx].data;
      end
    end
  end

  assign head_addr_o = entries_q[head_q].addr;
  assign head_data_o = entries_q[head_q].data;
  assign count_o     = count_q;
  assign full_o      = (count_q == CW'(DEPTH));
  assign empty_o     = (count_q == '0);

endmodule

// File: rtl/mem_write_buffer.sv
// Posted-write buffer between the core arbiter and physical memory: writes
// complete immediately into a FIFO, reads forward from it or go to memory.
module mem_write_buffer
  import mem_wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   clrn,
  input  logic [31:0]            c_a,
  input  logic [31:0]            c_d_w,
  input  logic                   c_access,
  input  logic                   c_write,
  output logic [31:0]            c_d_r,
  output logic                   c_ready,
  output logic [31:0]            m_a,
  output logic [31:0]            m_d_w,
  output logic                   m_access,
  output logic                   m_write,
  input  logic [31:0]            m_d_r,
  input  logic                   m_ready,
  output logic                   wb_empty,
  output logic [$clog2(DEPTH):0] wb_count
);

  localparam int CW = $clog2(DEPTH) + 1;

  wb_state_e          state_q, state_d;
  logic               wr_req, rd_req, rd_miss;
  logic               push, pop;
  logic               hit, full, empty;
  logic [31:0]        hit_data, head_data;
  logic [31:WORD_LSB] head_addr;
  logic [CW-1:0]      count;

  assign wr_req  = c_access & c_write;
  assign rd_req  = c_access & ~c_write;
  assign push    = wr_req & ~full;
  assign rd_miss = rd_req & ~hit;
  assign pop     = (state_q == DRAIN) & m_ready;

  wb_entry_cam #(.DEPTH(DEPTH)) u_cam (
    .clk           (clk),
    .clrn          (clrn),
    .push_i        (push),
    .push_addr_i   (c_a[31:WORD_LSB]),
    .push_data_i   (c_d_w),
    .pop_i         (pop),
    .lookup_addr_i (c_a[31:WORD_LSB]),
    .hit_o         (hit),
    .hit_data_o    (hit_data),
    .head_addr_o   (head_addr),
    .head_data_o   (head_data),
    .count_o       (count),
    .full_o        (full),
    .empty_o       (empty)
  );

  always_comb begin
    c_ready = 1'b0;
    c_d_r   = '0;
    if (wr_req) begin
      c_ready = ~full;
    end else if (rd_req && hit) begin
      c_ready = 1'b1;
      c_d_r   = hit_data;
    end else if (rd_req && state_q == READ) begin
      c_ready = m_ready;
      c_d_r   = m_d_r;
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // A write landing while idle starts the drain on the very next cycle.
  always_comb begin
    state_d  = state_q;
    m_access = 1'b0;
    m_write  = 1'b0;
    m_a      = '0;
    m_d_w    = '0;
    unique case (state_q)
      IDLE: begin
        if (rd_miss)            state_d = READ;
        else if (!empty || push) state_d = DRAIN;
      end
      DRAIN: begin
        m_access = 1'b1;
        m_write  = 1'b1;
        m_a      = {head_addr, {WORD_LSB{1'b0}}};
        m_d_w    = head_data;
        if (m_ready) begin
          if (rd_miss)                     state_d = READ;
          else if (count > CW'(1) || push) state_d = DRAIN;
          else                             state_d = IDLE;
        end
      end
      READ: begin
        m_access = 1'b1;
        m_a      = c_a;
        if (m_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign wb_empty = empty;
  assign wb_count = count;

endmodule

// File: tb/tb_mem_write_buffer.sv
// Scoreboard bench for mem_write_buffer: directed scenarios plus random
// traffic checked against a queue/associative-array memory model.
`timescale 1ns/1ps
module tb_mem_write_buffer;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        clrn = 1'b0;
  logic [31:0] c_a = '0, c_d_w = '0, c_d_r;
  logic        c_access = 1'b0, c_write = 1'b0, c_ready;
  logic [31:0] m_a, m_d_w, m_d_r;
  logic        m_access, m_write, m_ready;
  logic        wb_empty;
  logic [$clog2(DEPTH):0] wb_count;

  mem_write_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .clrn(clrn), .c_a(c_a), .c_d_w(c_d_w), .c_access(c_access),
    .c_write(c_write), .c_d_r(c_d_r), .c_ready(c_ready), .m_a(m_a),
    .m_d_w(m_d_w), .m_access(m_access), .m_write(m_write), .m_d_r(m_d_r),
    .m_ready(m_ready), .wb_empty(wb_empty), .wb_count(wb_count)
  );

  always #5 clk = ~clk;

  typedef struct { logic [29:0] wa; logic [31:0] d; } wr_t;
  typedef struct { bit wr; logic [31:0] a; int start; int done; } txn_t;

  int checks = 0, failures = 0;
  int cyc = 0;
  wr_t         wq[$];               // accepted writes not yet in memory, oldest first
  logic [31:0] rq[$];               // expected read data, in issue order
  logic [31:0] mem[logic [29:0]];
  logic [31:0] latest[logic [29:0]];
  txn_t        mlog[$];
  bit          pop_pending = 0;
  bit          stall = 0;
  int          lat_min = 0, lat_max = 3;
  int          wait_cnt = -1, cur_start = 0;
  bit          cur_wr = 0;
  logic [31:0] cur_a = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] dflt(input logic [29:0] wa);
    return {wa, 2'b11} ^ 32'h5A5A_0000;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Memory responder: random or fixed latency, optional stall.
  initial begin
    m_ready = 1'b0;
    m_d_r   = '0;
    forever begin
      @(posedge clk); #1;
      if (!clrn) begin
        m_ready  = 1'b0;
        wait_cnt = -1;
      end else begin
        if (m_ready) begin
          m_ready  = 1'b0;
          wait_cnt = -1;
        end else if (wait_cnt >= 0) begin
          chk("m_access_held", {31'b0, m_access}, 32'd1);
          chk("m_write_held", {31'b0, m_write}, {31'b0, cur_wr});
          chk("m_a_held", m_a, cur_a);
          if (!m_access) wait_cnt = -1;
        end
        if (m_access && wait_cnt < 0) begin
          wait_cnt  = $urandom_range(lat_max, lat_min);
          cur_start = cyc;
          cur_wr    = m_write;
          cur_a     = m_a;
        end
        if (wait_cnt >= 0 && !stall) begin
          if (wait_cnt == 0) begin
            m_ready = 1'b1;
            m_d_r   = mem.exists(m_a[31:2]) ? mem[m_a[31:2]] : dflt(m_a[31:2]);
          end else begin
            wait_cnt--;
          end
        end
        if (!m_ready) m_d_r = $urandom;
      end
    end
  end

  // Downstream monitor: drains must match the posted-write queue in order.
  initial begin
    forever begin
      @(posedge clk);
      if (pop_pending) begin
        mem[wq[0].wa] = wq[0].d;
        void'(wq.pop_front());
        pop_pending = 0;
      end
      @(negedge clk);
      chk("wb_count", {29'b0, wb_count}, wq.size());
      chk("wb_empty", {31'b0, wb_empty}, {31'b0, wq.size() == 0});
      if (clrn && m_access && m_ready) begin
        mlog.push_back('{m_write, m_a, cur_start, cyc});
        if (m_write) begin
          if (wq.size() == 0) begin
            checks++; failures++;
            $display("FAIL drain_unexpected: got %h expected none", m_a);
          end else begin
            chk("drain_addr", m_a, {wq[0].wa, 2'b00});
            chk("drain_data", m_d_w, wq[0].d);
            pop_pending = 1;
          end
        end
      end
    end
  end

  // Upstream read monitor.
  initial begin
    forever begin
      @(negedge clk);
      if (clrn && c_access && !c_write && c_ready) begin
        if (rq.size() == 0) begin
          checks++; failures++;
          $display("FAIL read_unexpected: got %h expected none", c_d_r);
        end else begin
          chk("read_data", c_d_r, rq.pop_front());
        end
      end
    end
  end

  task automatic do_write(input logic [31:0] a, input logic [31:0] d);
    int n = 0;
    bit done = 0;
    @(posedge clk); #1;
    c_access = 1; c_write = 1; c_a = a; c_d_w = d;
    while (!done && n < 200) begin
      @(negedge clk);
      chk("wr_ready", {31'b0, c_ready}, {31'b0, wq.size() < DEPTH});
      if (c_ready) done = 1;
      n++;
    end
    if (!done) begin
      checks++; failures++;
      $display("FAIL wr_timeout: got no c_ready expected c_ready");
    end
    @(posedge clk);
    if (done) begin
      wq.push_back('{a[31:2], d});
      latest[a[31:2]] = d;
    end
    #1;
    c_access = 0; c_write = 0; c_a = $urandom; c_d_w = $urandom;
  endtask

  task automatic do_read(input logic [31:0] a);
    int n = 0;
    bit done = 0, hit = 0;
    @(posedge clk); #1;
    foreach (wq[i]) if (wq[i].wa == a[31:2]) hit = 1;
    rq.push_back(latest.exists(a[31:2]) ? latest[a[31:2]] : dflt(a[31:2]));
    c_access = 1; c_write = 0; c_a = a;
    @(negedge clk);
    chk("rd_first_cycle_ready", {31'b0, c_ready}, {31'b0, hit});
    done = c_ready;
    while (!done && n < 200) begin
      @(negedge clk);
      done = c_ready;
      n++;
    end
    if (!done) begin
      checks++; failures++;
      $display("FAIL rd_timeout: got no c_ready expected c_ready");
      void'(rq.pop_back());
    end
    @(posedge clk); #1;
    c_access = 0; c_a = $urandom;
  endtask

  task automatic wait_empty();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(wb_empty && !m_access) && n < 300);
    checks++;
    if (!(wb_empty && !m_access)) begin
      failures++;
      $display("FAIL drain_timeout: got count %0d expected 0", wb_count);
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #3;
    clrn = 0; c_access = 0; c_write = 0;
    wq.delete(); rq.delete(); pop_pending = 0;
    latest = mem;
    repeat (2) begin
      @(negedge clk);
      chk("rst_c_ready", {31'b0, c_ready}, 0);
      chk("rst_c_d_r", c_d_r, 0);
      chk("rst_m_access", {31'b0, m_access}, 0);
      chk("rst_m_write", {31'b0, m_write}, 0);
      chk("rst_m_a", m_a, 0);
      chk("rst_m_d_w", m_d_w, 0);
    end
    @(posedge clk); #3;
    clrn = 1;
    repeat (3) begin
      @(negedge clk);
      chk("post_rst_m_access", {31'b0, m_access}, 0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();

    // Single write, memory latency 3.
    lat_min = 3; lat_max = 3;
    do_write(32'h100, 32'hDEADBEEF);
    @(negedge clk);
    chk("sw_m_access", {31'b0, m_access}, 1);
    chk("sw_m_write", {31'b0, m_write}, 1);
    chk("sw_m_a", m_a, 32'h100);
    chk("sw_m_d_w", m_d_w, 32'hDEADBEEF);
    wait_empty();

    // Full buffer: fifth write held off until the cycle after the first pop.
    stall = 1; lat_min = 0; lat_max = 0;
    for (int i = 0; i < DEPTH; i++) do_write(32'h1000 + 32'(4 * i), $urandom);
    @(negedge clk);
    chk("full_count", {29'b0, wb_count}, DEPTH);
    fork
      do_write(32'h2000, 32'hCAFEF00D);
      begin repeat (4) @(posedge clk); #2; stall = 0; end
    join
    wait_empty();

    // Youngest-match forwarding with memory stalled.
    stall = 1;
    do_write(32'h200, 32'h11);
    do_write(32'h200, 32'h22);
    do_read(32'h200);
    @(negedge clk);
    chk("fwd_still_drain", {31'b0, m_write}, 1);
    stall = 0;
    wait_empty();

    // Read miss while draining: READ slots between the two drains.
    stall = 1; lat_min = 1; lat_max = 1;
    do_write(32'h10, 32'hA0A0_0010);
    do_write(32'h14, 32'hA0A0_0014);
    mlog.delete();
    fork
      do_read(32'h300);
      begin repeat (3) @(posedge clk); #2; stall = 0; end
    join
    wait_empty();
    chk("rmd_txn_count", mlog.size(), 3);
    if (mlog.size() >= 3) begin
      chk("rmd_0_addr", mlog[0].a, 32'h10);
      chk("rmd_1_addr", mlog[1].a, 32'h300);
      chk("rmd_1_is_read", {31'b0, mlog[1].wr}, 0);
      chk("rmd_no_bubble", mlog[1].start, mlog[0].done + 1);
      chk("rmd_2_addr", mlog[2].a, 32'h14);
    end

    // Random traffic over a small address set so hits and duplicates are common.
    for (int i = 0; i < 300; i++) begin
      logic [31:0] a;
      lat_min = 0;
      lat_max = ($urandom_range(0, 9) == 0) ? 8 : 3;
      a = 32'h4000 + 32'(4 * $urandom_range(0, 7)) + 32'($urandom_range(0, 3));
      if ($urandom_range(0, 9) < 6) do_write(a, $urandom);
      else                          do_read(a);
    end
    wait_empty();

    // Reset mid-drain abandons buffered writes.
    stall = 1; lat_min = 0; lat_max = 0;
    for (int i = 0; i < 3; i++) do_write(32'h5000 + 32'(4 * i), $urandom);
    @(negedge clk);
    chk("rmd_pre_count", {29'b0, wb_count}, 3);
    do_reset();
    stall = 0;
    repeat (10) begin
      @(negedge clk);
      chk("rst_drain_idle", {31'b0, m_access}, 0);
    end
    do_read(32'h5000);
    wait_empty();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_write_buffer.md
# mem_write_buffer

Posted-write buffer between the dual-core memory arbiter mux and `physical_memory`. It accepts arbitrated core requests on an upstream port and completes writes immediately into a small FIFO. Reads that hit a buffered address are forwarded from the buffer. All other traffic goes to memory over the existing `m_access`/`m_write`/`m_ready` handshake, so writes no longer stall a core for the full memory latency.

## Interface
- `DEPTH`, 4: buffer entries; power of two, ≥2
- `clk`  in  1  clock
- `clrn`  in  1  reset, asynchronous, active-low
- `c_a`  in  32  upstream byte address; bits [31:2] used as the word address
- `c_d_w`  in  32  upstream write data
- `c_access`  in  1  upstream request; held until `c_ready`
- `c_write`  in  1  upstream write enable
- `c_d_r`  out  32  upstream read data, valid while `c_ready` on a read
- `c_ready`  out  1  upstream completion, one cycle per request
- `m_a`  out  32  memory address
- `m_d_w`  out  32  memory write data
- `m_access`  out  1  memory request
- `m_write`  out  1  memory write enable
- `m_d_r`  in  32  memory read data
- `m_ready`  in  1  memory completion
- `wb_empty`  out  1  buffer holds no entries
- `wb_count`  out  $clog2(DEPTH)+1  occupied entries

## Operation
- **Protocol (both ports):** a requester holds a request until it sees ready. The transfer completes at the rising `clk` edge where access and ready are both 1.
- **Upstream write:**
  - If `wb_count < DEPTH`, `c_ready`=1 combinationally in the same cycle. {c_a, c_d_w} is pushed at the edge.
  - If the buffer is full, `c_ready`=0. A full buffer never accepts a write in the same cycle a pop frees a slot; acceptance happens the cycle after the pop.
- **Upstream read, hit:** `c_a[31:2]` matches any valid entry. The youngest matching entry's data drives `c_d_r` with `c_ready`=1 in the same cycle. There is no memory access.
- **Upstream read, miss:** the read is serviced by memory. `c_d_r`=`m_d_r` and `c_ready`=`m_ready` while in READ.
- **Duplicate addresses:** writes to an already-buffered address append a new entry; there is no merging. Drain order is strict FIFO.
- **Downstream FSM (states IDLE, DRAIN, READ; Moore outputs):**
  - IDLE: read miss pending → READ; else not empty → DRAIN; else stay.
  - DRAIN: `m_access`=1, `m_write`=1, `m_a`/`m_d_w`=head entry. On `m_ready`, pop; then read miss pending → READ, else count after pop > 0 → DRAIN, else → IDLE.
  - READ: `m_access`=1, `m_write`=0, `m_a`=`c_a`. On `m_ready` → IDLE.
- **Forwarding during a pop:** an entry being popped is still valid for forwarding in that cycle.
- **Simultaneous push and pop:** count unchanged; pointers both advance modulo DEPTH.
- **Reset:** all entries are invalidated and pointers zeroed; state → IDLE. Reset mid-DRAIN or mid-READ abandons the transaction, and buffered writes are lost.
- **Reset values:** `c_ready`=0, `c_d_r`=0, `m_access`=0, `m_write`=0, `m_a`=0, `m_d_w`=0, `wb_empty`=1, `wb_count`=0.

## Timing
- Write accept and read hit: 0 cycles (same-cycle `c_ready`).
- Read miss from an idle buffer: state enters READ at the next edge. Latency is 1 + memory latency cycles.
- Read miss during DRAIN: waits for the current drain to complete, then goes directly to READ with no IDLE bubble. Remaining entries drain after the read.
- Back-to-back drains: no bubble between entries.
- `m_access` never deasserts before `m_ready` within a transaction.

## Structure
- Package `mem_wb_pkg`: state enum (IDLE, DRAIN, READ), `WORD_LSB`=2, and the entry struct {addr[31:2], data[31:0], valid}.
- Sub-module `wb_entry_cam`:
  - holds the FIFO storage, pointers and count;
  - performs the youngest-match search, a priority search from the tail backwards;
  - outputs `hit` and `hit_data`.
- The top level holds the FSM and the port muxing.

## Test plan
- **Reset:** assert `clrn`=0 mid-stream → all outputs at reset values; `wb_empty`=1 and `m_access`=0 from the first edge after release.
- **Single write:** write 0x100=0xDEADBEEF with memory latency 3 → `c_ready` the same cycle. Next cycle `m_access`=`m_write`=1 with `m_a`=0x100; pop on `m_ready`; `wb_empty`=1 afterwards.
- **Full buffer:** `m_ready` held 0, four writes → all accepted and `wb_count`=4. A fifth write sees `c_ready`=0 until one cycle after the first pop.
- **Youngest-match forwarding:** write 0x200=0x11, then 0x200=0x22, then read 0x200 → `c_d_r`=0x22 with `c_ready` the same cycle; no read on the memory port.
- **Read miss during drain:** buffer holds 0x10 and 0x14 with the 0x10 drain active; read 0x300 → READ follows the 0x10 completion, `c_d_r`=`m_d_r`, then 0x14 drains.
- **Reset mid-DRAIN:** reset with 3 entries buffered → `wb_count`=0; no further `m_access` after release.
